// File: rtl/ad9910_spi_pkg.sv
// Shared types and helpers for the AD9910 serial-port master.
package ad9910_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        RECOVER,
        DONE
    } state_t;

    localparam int MAX_BYTES_DEFAULT = 8;
    localparam int READ_BIT          = 7;

    // Half SCLK period in system clocks; never below one cycle.
    function automatic logic [7:0] half_period(input logic [7:0] divide);
        logic [7:0] h;
        h = {1'b0, divide[7:1]};
        return (h == 8'd0) ? 8'd1 : h;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter marking the last cycle of each SCLK/CSB phase.
module spi_phase_timer (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] value,
    output logic       phase_end
);

    logic [7:0] cnt;

    // Load on a phase boundary, otherwise count down and park at zero.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign phase_end = (cnt == 8'd0);

endmodule

// File: rtl/ad9910_spi_engine.sv
// AD9910 4-wire serial-port master: instruction byte plus 1..MAX_BYTES data
// bytes, MSB first, with optional SDO capture on read instructions.
module ad9910_spi_engine
    import ad9910_spi_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) (
    input  logic                   CLK100MHZ,
    input  logic                   reset,
    input  logic [7:0]             divide,
    input  logic                   start,
    input  logic [7:0]             instr,
    input  logic [3:0]             nbytes,
    input  logic [8*MAX_BYTES-1:0] data_in,
    output logic                   busy,
    output logic                   done,
    output logic [8*MAX_BYTES-1:0] data_out,
    output logic                   sclk,
    output logic                   csb,
    output logic                   sdio,
    input  logic                   sdo
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int TW = DW + 8;

    state_t          state;
    logic [TW-1:0]   tx;
    logic [DW-1:0]   rx;
    logic            is_read;
    logic [7:0]      nbits;
    logic [7:0]      bit_cnt;
    logic [7:0]      half_m1;

    logic [3:0]      nb_clamp;
    logic [7:0]      shamt;
    logic            last_bit;
    logic            tmr_load;
    logic [7:0]      tmr_value;
    logic            phase_end;

    // Clamp the requested byte count and derive the left-align shift for data_in.
    always_comb begin
        nb_clamp = nbytes;
        if (nbytes == 4'd0) begin
            nb_clamp = 4'd1;
        end else if (int'(nbytes) > MAX_BYTES) begin
            nb_clamp = 4'(MAX_BYTES);
        end
        shamt = 8'(8 * (MAX_BYTES - int'(nb_clamp)));
    end

    assign last_bit = (bit_cnt == nbits - 8'd1);

    // Reload the timer at accept and at every phase boundary of an active transfer.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = half_m1;
        case (state)
            IDLE: begin
                tmr_load  = start;
                tmr_value = half_period(divide) - 8'd1;
            end
            SETUP, SHIFT, RECOVER: tmr_load = phase_end;
            default: tmr_load = 1'b0;
        endcase
    end

    spi_phase_timer u_timer (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .load      (tmr_load),
        .value     (tmr_value),
        .phase_end (phase_end)
    );

    // Transaction FSM; all pin and handshake outputs are registered here.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            csb      <= 1'b1;
            sclk     <= 1'b0;
            sdio     <= 1'b0;
            data_out <= '0;
            tx       <= '0;
            rx       <= '0;
            is_read  <= 1'b0;
            nbits    <= 8'd0;
            bit_cnt  <= 8'd0;
            half_m1  <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        half_m1 <= half_period(divide) - 8'd1;
                        is_read <= instr[READ_BIT];
                        nbits   <= 8'd8 + {1'b0, nb_clamp, 3'b000};
                        tx      <= {instr, data_in << shamt};
                        rx      <= '0;
                        bit_cnt <= 8'd0;
                        if (instr[READ_BIT]) begin
                            data_out <= '0;
                        end
                        busy  <= 1'b1;
                        csb   <= 1'b0;
                        sdio  <= instr[READ_BIT];
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    // Bit 0 is always an instruction bit, so nothing to capture here.
                    if (phase_end) begin
                        sclk  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (phase_end) begin
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (!last_bit) begin
                                tx   <= tx << 1;
                                sdio <= tx[TW-2];
                            end
                        end else if (last_bit) begin
                            csb   <= 1'b1;
                            sdio  <= 1'b0;
                            state <= RECOVER;
                        end else begin
                            sclk    <= 1'b1;
                            bit_cnt <= bit_cnt + 8'd1;
                            // Capture only data bits (index 8 and up) on reads.
                            if (is_read && bit_cnt >= 8'd7) begin
                                rx <= {rx[DW-2:0], sdo};
                            end
                        end
                    end
                end
                RECOVER: begin
                    if (phase_end) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        if (is_read) begin
                            data_out <= rx;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // One dead cycle so a start coincident with done is dropped.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9910_spi_engine.sv
// Directed bench for ad9910_spi_engine: vector table plus corner sequences.
module tb_ad9910_spi_engine;

    logic        CLK100MHZ = 1'b0;
    logic        reset     = 1'b0;
    logic [7:0]  divide    = 8'd0;
    logic        start     = 1'b0;
    logic [7:0]  instr     = 8'd0;
    logic [3:0]  nbytes    = 4'd0;
    logic [63:0] data_in   = 64'd0;
    logic        busy, done, sclk, csb, sdio;
    logic [63:0] data_out;
    logic        sdo_m     = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    ad9910_spi_engine #(.MAX_BYTES(8)) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .divide    (divide),
        .start     (start),
        .instr     (instr),
        .nbytes    (nbytes),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .sclk      (sclk),
        .csb       (csb),
        .sdio      (sdio),
        .sdo       (sdo_m)
    );

    // DDS model: after the 8th falling SCLK edge, present dds_word MSB first.
    logic [63:0] dds_word = 64'd0;
    int          falls    = 0;
    always @(negedge sclk or posedge csb) begin
        if (csb) begin
            falls = 0;
            sdo_m = 1'b1;
        end else begin
            falls = falls + 1;
            if (falls >= 8) begin
                sdo_m = (falls - 8 < 64) ? dds_word[63 - (falls - 8)] : 1'b0;
            end
        end
    end

    // Pin monitor sampled on the falling system-clock edge.
    logic         prev_sclk = 1'b0, prev_csb = 1'b1;
    int           rise_total = 0, done_total = 0;
    int           low_run = 0, high_run = 0, last_low = 0, last_high = 0;
    int           gap = 0, done_gap = 0;
    logic         done_busy = 1'b0;
    logic [127:0] sdio_sr = '0;
    always @(negedge CLK100MHZ) begin
        int g;
        g = (csb && !prev_csb) ? 0 : gap + 1;
        gap <= g;
        if (done) begin
            done_total <= done_total + 1;
            done_gap   <= g;
            done_busy  <= busy;
        end
        if (sclk && !prev_sclk) begin
            rise_total <= rise_total + 1;
            sdio_sr    <= {sdio_sr[126:0], sdio};
        end
        if (!csb) begin
            low_run <= low_run + 1;
            if (prev_csb) last_high <= high_run;
            high_run <= 0;
        end else begin
            high_run <= high_run + 1;
            if (!prev_csb) last_low <= low_run;
            low_run <= 0;
        end
        prev_sclk <= sclk;
        prev_csb  <= csb;
    end

    typedef struct {
        logic [7:0]  divide;
        logic [7:0]  instr;
        logic [3:0]  nbytes;
        logic [63:0] data_in;
        logic [63:0] dds;
        int          exp_low;
        int          exp_rises;
        int          exp_gap;
        logic [63:0] exp_dout;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nbc_of(input logic [3:0] nb);
        if (nb == 4'd0) return 1;
        if (nb > 4'd8) return 8;
        return int'(nb);
    endfunction

    // Called at a falling edge; start is high for exactly one cycle.
    task automatic start_xfer(input logic [7:0] d, input logic [7:0] ins,
                              input logic [3:0] nb, input logic [63:0] din);
        divide  = d;
        instr   = ins;
        nbytes  = nb;
        data_in = din;
        start   = 1'b1;
        @(negedge CLK100MHZ);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done) begin ok = 1; break; end
            @(negedge CLK100MHZ);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done, expected done within 3000 cycles", tag);
        end
    endtask

    // Compare monitor results of the transfer just finished against v.
    task automatic check_result(input string tag, input vec_t v, input int br, input int bd);
        int           nbc;
        int           n;
        logic [127:0] mask;
        logic [127:0] exp_s;
        logic [63:0]  dmask;
        nbc = nbc_of(v.nbytes);
        n   = 8 + 8 * nbc;
        check({tag, "_csb_low"}, 128'(last_low), 128'(v.exp_low));
        check({tag, "_rises"}, 128'(rise_total - br), 128'(v.exp_rises));
        check({tag, "_done_cnt"}, 128'(done_total - bd), 128'd1);
        check({tag, "_done_gap"}, 128'(done_gap), 128'(v.exp_gap));
        check({tag, "_busy_at_done"}, 128'(done_busy), 128'd0);
        check({tag, "_data_out"}, 128'(data_out), 128'(v.exp_dout));
        if (v.instr[7]) begin
            check({tag, "_sdio_instr"}, (sdio_sr >> (8 * nbc)) & 128'hFF, 128'(v.instr));
        end else begin
            mask  = (128'd1 << n) - 128'd1;
            dmask = (64'd1 << (8 * nbc)) - 64'd1;
            exp_s = ({120'd0, v.instr} << (8 * nbc)) | {64'd0, v.data_in & dmask};
            check({tag, "_sdio"}, sdio_sr & mask, exp_s);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int br, bd;
        br = rise_total;
        bd = done_total;
        dds_word = v.dds << (64 - 8 * nbc_of(v.nbytes));
        start_xfer(v.divide, v.instr, v.nbytes, v.data_in);
        wait_done(tag);
        @(negedge CLK100MHZ);
        check_result(tag, v, br, bd);
    endtask

    vec_t vt[7];

    initial begin
        vec_t v;
        int   br, bd;

        vt[0] = '{8'd4, 8'h0E, 4'd1,  64'hA5,               64'd0,                 66,  16, 2, 64'd0};
        vt[1] = '{8'd2, 8'h8E, 4'd8,  64'd0,                64'h0123456789ABCDEF,  145, 72, 1, 64'h0123456789ABCDEF};
        vt[2] = '{8'd0, 8'h01, 4'd0,  64'h3C,               64'd0,                 33,  16, 1, 64'h0123456789ABCDEF};
        vt[3] = '{8'd1, 8'h01, 4'd0,  64'h3C,               64'd0,                 33,  16, 1, 64'h0123456789ABCDEF};
        vt[4] = '{8'd2, 8'h02, 4'd12, 64'h1122334455667788, 64'd0,                 145, 72, 1, 64'h0123456789ABCDEF};
        vt[5] = '{8'd6, 8'h85, 4'd1,  64'd0,                64'h5A,                99,  16, 3, 64'h5A};
        vt[6] = '{8'd3, 8'h40, 4'd2,  64'hBEEF,             64'd0,                 49,  24, 1, 64'h5A};

        // Reset state.
        repeat (3) @(negedge CLK100MHZ);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_csb", 128'(csb), 128'd1);
        check("rst_sclk", 128'(sclk), 128'd0);
        check("rst_sdio", 128'(sdio), 128'd0);
        check("rst_data_out", 128'(data_out), 128'd0);
        reset = 1'b1;
        repeat (2) @(negedge CLK100MHZ);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("v%0d", i), vt[i]);
            repeat (2) @(negedge CLK100MHZ);
        end

        // start pulsed mid-transfer and in the done cycle must be dropped.
        v  = '{8'd2, 8'h03, 4'd2, 64'hC0DE, 64'd0, 49, 24, 1, 64'h5A};
        br = rise_total;
        bd = done_total;
        start_xfer(v.divide, v.instr, v.nbytes, v.data_in);
        repeat (10) @(negedge CLK100MHZ);
        start_xfer(8'd0, 8'h8F, 4'd1, 64'd0);
        wait_done("ign");
        start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        check_result("ign", v, br, bd);
        repeat (3) @(negedge CLK100MHZ);
        check("ign_busy_after", 128'(busy), 128'd0);
        check("ign_csb_after", 128'(csb), 128'd1);
        check("ign_done_after", 128'(done_total - bd), 128'd1);

        // Back-to-back: start one cycle after done is accepted.
        run_vec("b2b_a", '{8'd2, 8'h04, 4'd1, 64'h77, 64'd0, 33, 16, 1, 64'h5A});
        v  = '{8'd2, 8'h05, 4'd1, 64'h88, 64'd0, 33, 16, 1, 64'h5A};
        br = rise_total;
        bd = done_total;
        start_xfer(v.divide, v.instr, v.nbytes, v.data_in);
        check("b2b_busy", 128'(busy), 128'd1);
        wait_done("b2b_b");
        @(negedge CLK100MHZ);
        check_result("b2b_b", v, br, bd);
        check("b2b_csb_high", 128'(last_high), 128'd3);
        repeat (2) @(negedge CLK100MHZ);

        // Inputs changed mid-transfer are ignored.
        v  = '{8'd4, 8'h09, 4'd2, 64'h1234, 64'd0, 98, 24, 2, 64'h5A};
        br = rise_total;
        bd = done_total;
        start_xfer(v.divide, v.instr, v.nbytes, v.data_in);
        repeat (5) @(negedge CLK100MHZ);
        divide  = 8'd0;
        data_in = 64'hFFFF;
        instr   = 8'h80;
        nbytes  = 4'd8;
        wait_done("chg");
        @(negedge CLK100MHZ);
        check_result("chg", v, br, bd);
        repeat (2) @(negedge CLK100MHZ);

        // Reset at bit 20 of a 72-bit write.
        br = rise_total;
        bd = done_total;
        start_xfer(8'd2, 8'h06, 4'd8, 64'hDEADBEEFCAFEF00D);
        begin
            bit hit = 0;
            for (int k = 0; k < 2000; k++) begin
                @(negedge CLK100MHZ);
                if (rise_total - br >= 20) begin hit = 1; break; end
            end
            check("mid_rst_reached_bit20", 128'(hit), 128'd1);
        end
        reset = 1'b0;
        #1;
        check("mid_rst_csb", 128'(csb), 128'd1);
        check("mid_rst_sclk", 128'(sclk), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_data_out", 128'(data_out), 128'd0);
        repeat (3) @(negedge CLK100MHZ);
        check("mid_rst_no_done", 128'(done_total - bd), 128'd0);
        reset = 1'b1;
        repeat (2) @(negedge CLK100MHZ);
        run_vec("post_rst", '{8'd2, 8'h07, 4'd3, 64'hABCDEF, 64'd0, 65, 32, 1, 64'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
